// File: rtl/pc_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
//  pc_pkg
//  Shared sequencing opcodes, PC-stage states and ALU flag indices.
//  Rev 1.0
// ------------------------------------------------------------------
package pc_pkg;

    // Sequencing opcodes driven by the decoder
    typedef enum logic [2:0] {
        PC_NEXT = 3'd0,
        PC_JMP  = 3'd1,
        PC_BEQ  = 3'd2,
        PC_BNE  = 3'd3,
        PC_BCS  = 3'd4,
        PC_BMI  = 3'd5,
        PC_WAIT = 3'd6,
        PC_HALT = 3'd7
    } pc_op_t;

    // Sequencer states
    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_WAIT_HI = 2'd1,
        S_WAIT_LO = 2'd2,
        S_HALT    = 2'd3
    } pc_state_t;

    // Bit positions inside the {V,N,Z,C} flag vector
    localparam int FLAG_V = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ------------------------------------------------------------------
//  sync2
//  Two-flop synchronizer for slow asynchronous board inputs.
//  Rev 1.0
// ------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic n_reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw input through two flops to settle metastability
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
//  pc_ctrl
//  Program counter / sequencer: relative branches on latched flags,
//  WAIT-for-switch press/release handshake and HALT.
//  Rev 1.0
// ------------------------------------------------------------------
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int Psize = 6
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [2:0]       op,
    input  logic [Psize-1:0] offset,
    input  logic [3:0]       flags,
    input  logic             flags_we,
    input  logic             sw8,
    output logic [Psize-1:0] pc,
    output logic [3:0]       flags_q,
    output logic             stall,
    output logic             halted
);

    localparam logic [Psize-1:0] PC_ONE = {{(Psize-1){1'b0}}, 1'b1};

    pc_state_t state;
    pc_op_t    op_e;
    logic      sw8_s;
    logic      take;

    assign op_e = pc_op_t'(op);

    sync2 u_sync_sw8 (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (sw8),
        .q       (sw8_s)
    );

    // Branch decision, always against the previously latched flags
    always_comb begin
        take = 1'b0;
        case (op_e)
            PC_JMP:  take = 1'b1;
            PC_BEQ:  take = flags_q[FLAG_Z];
            PC_BNE:  take = ~flags_q[FLAG_Z];
            PC_BCS:  take = flags_q[FLAG_C];
            PC_BMI:  take = flags_q[FLAG_N];
            default: take = 1'b0;
        endcase
    end

    // Sequencer FSM: pc, flag latch and state advance together
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= S_RUN;
            pc      <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (flags_we) begin
                        flags_q <= flags;
                    end
                    case (op_e)
                        PC_WAIT: state <= S_WAIT_HI;
                        PC_HALT: state <= S_HALT;
                        // Offset is Psize wide, so the sum wraps naturally
                        default: pc <= take ? (pc + offset) : (pc + PC_ONE);
                    endcase
                end
                S_WAIT_HI: begin
                    if (sw8_s) begin
                        state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!sw8_s) begin
                        state <= S_RUN;
                        pc    <= pc + PC_ONE;
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

    assign stall  = (state != S_RUN);
    assign halted = (state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
//  tb_pc_ctrl
//  Directed self-checking bench for pc_ctrl.
//  Rev 1.0
// ------------------------------------------------------------------
module tb_pc_ctrl;

    localparam int PSIZE = 6;

    logic             clk;
    logic             n_reset;
    logic [2:0]       op;
    logic [PSIZE-1:0] offset;
    logic [3:0]       flags;
    logic             flags_we;
    logic             sw8;
    logic [PSIZE-1:0] pc;
    logic [3:0]       flags_q;
    logic             stall;
    logic             halted;

    int vectors;
    int miscompares;

    pc_ctrl #(.Psize(PSIZE)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .op       (op),
        .offset   (offset),
        .flags    (flags),
        .flags_we (flags_we),
        .sw8      (sw8),
        .pc       (pc),
        .flags_q  (flags_q),
        .stall    (stall),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Async reset pulse between edges, then run NEXT n times
    task automatic reset_and_go(input int n);
        op       = 3'd0;
        offset   = '0;
        flags    = '0;
        flags_we = 1'b0;
        sw8      = 1'b0;
        n_reset  = 1'b0;
        #2;
        n_reset  = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        n_reset     = 1'b0;
        op          = 3'd0;
        offset      = '0;
        flags       = '0;
        flags_we    = 1'b0;
        sw8         = 1'b0;
        #3;
        n_reset = 1'b1;
        step();

        // Reset from a running state with nonzero pc and flags
        reset_and_go(40);
        flags_we = 1'b1;
        flags    = 4'hF;
        step();
        flags_we = 1'b0;
        step();
        check("preload_pc", 32'(pc), 32'h2A);
        check("preload_flags", 32'(flags_q), 32'hF);
        n_reset = 1'b0;
        #1;
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_flags", 32'(flags_q), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        #1;

        // Sequential count with wrap at 64
        n_reset = 1'b1;
        for (int i = 0; i < 70; i++) begin
            check("seq_pc", 32'(pc), 32'(i % 64));
            step();
        end

        // BEQ taken at pc=10 after Z latched
        reset_and_go(9);
        flags_we = 1'b1;
        flags    = 4'b0010;
        step();
        flags_we = 1'b0;
        check("beq_setup_pc", 32'(pc), 32'd10);
        op     = 3'd2;
        offset = 6'h3D;
        step();
        check("beq_pc", 32'(pc), 32'd7);

        // BNE not taken with Z set
        reset_and_go(9);
        flags_we = 1'b1;
        flags    = 4'b0010;
        step();
        flags_we = 1'b0;
        op     = 3'd3;
        offset = 6'h3D;
        step();
        check("bne_pc", 32'(pc), 32'd11);

        // Same-cycle flag write and BCS uses the old flags
        reset_and_go(20);
        check("haz_setup_pc", 32'(pc), 32'd20);
        flags_we = 1'b1;
        flags    = 4'b0001;
        op       = 3'd4;
        offset   = 6'd5;
        step();
        flags_we = 1'b0;
        check("haz_pc", 32'(pc), 32'd21);
        check("haz_flags", 32'(flags_q), 32'b0001);
        step();
        check("bcs_taken_pc", 32'(pc), 32'd26);

        // Zero-offset JMP holds pc without stalling
        op     = 3'd1;
        offset = '0;
        step();
        check("jmp0_pc", 32'(pc), 32'd26);
        check("jmp0_stall", 32'(stall), 32'd0);

        // WAIT handshake at pc=3
        reset_and_go(3);
        op = 3'd6;
        step();
        op = 3'd0;
        check("wait_entry_pc", 32'(pc), 32'd3);
        check("wait_entry_stall", 32'(stall), 32'd1);
        flags_we = 1'b1;
        flags    = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            check("wait_lo_pc", 32'(pc), 32'd3);
            check("wait_lo_stall", 32'(stall), 32'd1);
        end
        sw8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("wait_hi_pc", 32'(pc), 32'd3);
            check("wait_hi_stall", 32'(stall), 32'd1);
        end
        sw8      = 1'b0;
        flags_we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("wait_rel_pc", 32'(pc), 32'd3);
            check("wait_rel_stall", 32'(stall), 32'd1);
        end
        step();
        check("wait_exit_pc", 32'(pc), 32'd4);
        check("wait_exit_stall", 32'(stall), 32'd0);
        check("wait_flags_ignored", 32'(flags_q), 32'd0);

        // HALT at pc=9, random inputs cannot move it
        reset_and_go(9);
        op = 3'd7;
        step();
        check("halt_pc", 32'(pc), 32'd9);
        check("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            op       = 3'($urandom_range(0, 7));
            sw8      = 1'($urandom_range(0, 1));
            flags_we = 1'($urandom_range(0, 1));
            flags    = 4'($urandom_range(0, 15));
            offset   = 6'($urandom_range(0, 63));
            step();
            check("halt_hold_pc", 32'(pc), 32'd9);
            check("halt_hold_halted", 32'(halted), 32'd1);
            check("halt_hold_stall", 32'(stall), 32'd1);
        end
        n_reset = 1'b0;
        #1;
        check("halt_rst_pc", 32'(pc), 32'd0);
        check("halt_rst_halted", 32'(halted), 32'd0);
        check("halt_rst_stall", 32'(stall), 32'd0);
        #1;
        n_reset = 1'b1;
        op      = 3'd0;
        step();
        check("post_rst_pc", 32'(pc), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter and sequencing stage for picoMIPS. It sits downstream of the ALU: it latches the ALU's V,N,Z,C flags and uses them to choose the next program address, which addresses the program memory feeding the decoder. It also provides the blocking WAIT-for-switch handshake on `switches[8]` and a HALT state. While stalled, the decoder must suppress register-file writes.

## Interface
- `Psize`, 6, program address width in bits. The program memory depth is 2^Psize.
- `clk`  in  1  system clock. All state updates on the rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `op`  in  3  sequencing opcode from the decoder. Codes are in `pc_pkg`.
- `offset`  in  Psize  signed two's-complement relative branch offset, taken from the instruction immediate field.
- `flags`  in  4  ALU flags {V,N,Z,C}, bits 3..0.
- `flags_we`  in  1  capture `flags` into `flags_q` at this edge.
- `sw8`  in  1  raw `switches[8]`. Asynchronous to `clk`.
- `pc`  out  Psize  current program address. Registered.
- `flags_q`  out  4  latched flags {V,N,Z,C}. Registered.
- `stall`  out  1  high when the state is not RUN. Combinational from the state register.
- `halted`  out  1  high in HALT.

## Operation
- Opcodes:
  - `PC_NEXT`=0
  - `PC_JMP`=1 (unconditional relative)
  - `PC_BEQ`=2 (Z=1)
  - `PC_BNE`=3 (Z=0)
  - `PC_BCS`=4 (C=1)
  - `PC_BMI`=5 (N=1)
  - `PC_WAIT`=6
  - `PC_HALT`=7
- States: RUN, WAIT_HI, WAIT_LO, HALT (`pc_state_t`).
- In RUN:
  - If the branch is taken: `pc <= pc + offset`, with offset sign-extended and the sum taken mod 2^Psize.
  - Otherwise: `pc <= pc + 1`, mod 2^Psize.
  - A not-taken conditional branch behaves like `PC_NEXT`.
- Branch conditions test `flags_q`, never `flags`. When `flags_we` and a branch occur in the same cycle, the branch uses the old `flags_q`; the new value is visible from the next cycle.
- `flags_we` is honoured only in RUN. It is ignored in WAIT_HI, WAIT_LO and HALT.
- `PC_WAIT` in RUN: `pc` holds and the state goes to WAIT_HI.
  - WAIT_HI → WAIT_LO when `sw8_s`=1.
  - WAIT_LO → RUN when `sw8_s`=0, and at that same edge `pc <= pc + 1`.
  - The net effect is one full press and release of the switch.
- `PC_HALT` in RUN: `pc` holds and the state goes to HALT. HALT is left only by reset.
- `op` is ignored in every state except RUN.
- `sw8_s` is the output of a 2-flop synchronizer on `sw8`. Both flops reset to 0.
- An `offset` of 0 on a taken branch holds `pc`. This is a legal tight loop and is not treated as HALT.

## Timing
- Reset (async assert; deassert sampled on `clk`) forces:
  - `pc`=0, `flags_q`=0, state RUN
  - `stall`=0, `halted`=0
  - both synchronizer flops = 0
- Reset asserted mid-WAIT or in HALT returns to RUN/`pc`=0 immediately, with no clock needed.
- Branch latency: `op` is sampled at edge k, and `pc` shows the new address after edge k.
- `stall` rises in the cycle after the edge that accepted `PC_WAIT`/`PC_HALT`. It falls in the same cycle that `pc` advances out of WAIT_LO.
- Switch latency: a `sw8` rise is seen as `sw8_s` 2 edges later, and the WAIT_HI → WAIT_LO transition happens on the 3rd edge. A release is handled the same way.
- A press shorter than one clock may be missed. No debounce is applied; the board provides it.

## Structure
- `pc_pkg` holds:
  - the `pc_op_t` enum (3-bit, the codes above)
  - `pc_state_t` (2-bit)
  - the flag bit indices `FLAG_V`=3, `FLAG_N`=2, `FLAG_Z`=1, `FLAG_C`=0, shared with the ALU and decoder
- Sub-module `sync2`: 2-flop synchronizer with async active-low reset, reused for the other switch inputs.
- Branch-condition evaluation is a combinational `always_comb` inside `pc_ctrl`.

## Test plan
- Reset: hold `n_reset`=0 with `pc`=0x2A pre-loaded by running forward, then assert reset between edges. Required: `pc`=0, `flags_q`=0 and `stall`=0 immediately.
- Sequential and wrap (Psize=6): 70 cycles of `PC_NEXT` from reset. Required: `pc` reads 0,1,…,63,0,…,5.
- Conditional branches at `pc`=10:
  - `flags_we` with flags=4'b0010, next cycle `PC_BEQ` offset=-3. Required: `pc`=7.
  - Same setup with `PC_BNE` offset=-3. Required: `pc`=11.
- Same-cycle hazard: `flags_q`=0 and, in one cycle, `flags_we` with flags=4'b0001 plus `PC_BCS` offset=5 at `pc`=20. Required: not taken, `pc`=21, and `flags_q`=4'b0001 afterwards.
- WAIT handshake: `PC_WAIT` at `pc`=3, then `sw8` low for 5 cycles, high for 4, low.
  - Required: `stall`=1 and `pc`=3 throughout.
  - `flags_we` pulses are ignored.
  - `pc`=4 and `stall`=0 three edges after the release.
- HALT and reset recovery: `PC_HALT` at `pc`=9, then 20 cycles of random `op`/`sw8`.
  - Required: `pc`=9 and `halted`=1 held.
  - After reset: `pc`=0 and `halted`=0.
